touch_btn_counter: RTL

TOUCH_BTN_COUNTER -- requirements
Module: touch_btn_counter

---
 rtl/touch_btn_pkg.sv | 30 +++
 rtl/touch_btn_sat_cnt.sv | 32 +++
 rtl/touch_btn_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/touch_btn_pkg.sv
// Shared types and constants for the touch-button step counter.
// The REPEAT state exists only when TOUCH_BTN_AUTOREPEAT_EN is defined.
package touch_btn_pkg;

    localparam int TIMER_W = 25;
    localparam int CNT_W   = 16;

    localparam int DEF_DEBOUNCE_CYC  = 500000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;
    localparam int DEF_CNT_MAX       = 9999;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
`ifdef TOUCH_BTN_AUTOREPEAT_EN
        REPEAT,
`endif
        RELEASE
    } state_t;

    // Largest interval the shared timer ever has to measure.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/touch_btn_sat_cnt.sv
// Saturating up/down counter; clear wins over a coincident step.
module touch_btn_sat_cnt
    import touch_btn_pkg::*;
#(
    parameter int CNT_MAX = DEF_CNT_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (step) begin
            if (dir && (count != MAX_V)) begin
                count <= count + 1'b1;
            end else if (!dir && (count != '0)) begin
                count <= count - 1'b1;
            end
        end
    end

    assign at_limit = (count == '0) || (count == MAX_V);

endmodule

// File: rtl/touch_btn_counter.sv
// Debounced touch-button step counter with optional auto-repeat
// (enabled by defining TOUCH_BTN_AUTOREPEAT_EN).
module touch_btn_counter
    import touch_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_MAX       = DEF_CNT_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit_incr,
    input  logic             hit_decr,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             step_pulse,
    output logic             step_dir,
    output logic             at_limit
);

    localparam logic [TIMER_W-1:0] DEB_LAST  = TIMER_W'(DEBOUNCE_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMER_TOP =
        TIMER_W'(max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD));
`ifdef TOUCH_BTN_AUTOREPEAT_EN
    localparam logic [TIMER_W-1:0] DLY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PER_LAST  = TIMER_W'(REPEAT_PERIOD - 1);
`endif

    state_t               state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n, timer_inc;
    logic                 dir_r, dir_n;
    logic                 step_req;
    logic                 valid_hit;
    logic                 same_hit;

    assign valid_hit = hit_incr ^ hit_decr;
    assign same_hit  = valid_hit && (hit_incr == dir_r);
    // Timer holds at its terminal value instead of wrapping.
    assign timer_inc = (timer >= TIMER_TOP) ? timer : timer + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            dir_r      <= 1'b1;
            step_pulse <= 1'b0;
            step_dir   <= 1'b1;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            dir_r      <= dir_n;
            step_pulse <= step_req;
            if (step_req) begin
                step_dir <= dir_r;
            end
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        dir_n    = dir_r;
        step_req = 1'b0;
        case (state)
            IDLE: begin
                if (valid_hit) begin
                    dir_n   = hit_incr;
                    timer_n = TIMER_W'(1);
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!same_hit) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (timer >= DEB_LAST) begin
                    state_n  = PRESSED;
                    timer_n  = '0;
                    step_req = 1'b1;
                end else begin
                    timer_n = timer_inc;
                end
            end
            PRESSED: begin
                if (!same_hit) begin
                    state_n = RELEASE;
                    timer_n = TIMER_W'(1);
`ifdef TOUCH_BTN_AUTOREPEAT_EN
                end else if (timer >= DLY_LAST) begin
                    state_n  = REPEAT;
                    timer_n  = '0;
                    step_req = 1'b1;
`endif
                end else begin
                    timer_n = timer_inc;
                end
            end
`ifdef TOUCH_BTN_AUTOREPEAT_EN
            REPEAT: begin
                if (!same_hit) begin
                    state_n = RELEASE;
                    timer_n = TIMER_W'(1);
                end else if (timer >= PER_LAST) begin
                    timer_n  = '0;
                    step_req = 1'b1;
                end else begin
                    timer_n = timer_inc;
                end
            end
`endif
            RELEASE: begin
                // Any bounce back to a hit restarts the quiet-time window.
                if (valid_hit) begin
                    timer_n = TIMER_W'(1);
                end else if (timer >= DEB_LAST) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer_inc;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    touch_btn_sat_cnt #(
        .CNT_MAX (CNT_MAX)
    ) u_sat_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .step     (step_req),
        .dir      (dir_r),
        .count    (count),
        .at_limit (at_limit)
    );

endmodule
